// File: rtl/sine_phase_sequencer.sv
// Sine LUT read sequencer: phase accumulator drives the LUT address, samples land in a 1-deep valid/ready register.
// Optional SINE_SEQ_PHASE_OFFSET_EN adds offset_i as the latched start phase.
module sine_phase_sequencer #(
    parameter  int depth_p = 100,
    parameter  int width_p = 12,
    parameter  int frac_p  = 8,
    localparam int aw      = $clog2(depth_p),
    localparam int pw      = aw + frac_p
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      start_i,
    input  logic                      stop_i,
    input  logic [pw-1:0]             step_i,
`ifdef SINE_SEQ_PHASE_OFFSET_EN
    input  logic [pw-1:0]             offset_i,
`endif
    output logic [aw-1:0]             rd_addr_o,
    input  logic signed [width_p-1:0] rd_data_i,
    output logic signed [width_p-1:0] data_o,
    output logic                      valid_o,
    input  logic                      ready_i,
    output logic                      wrap_o,
    output logic                      busy_o
);

    localparam logic [pw:0]   phase_span = (pw+1)'(depth_p) << frac_p;
    localparam logic [pw-1:0] phase_max  = pw'(phase_span - 1'b1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        STOPPING
    } state_t;

    state_t                    state_q, state_d;
    logic [pw-1:0]             phase_q, step_q;
    logic signed [width_p-1:0] data_q;
    logic                      valid_q, wrap_q;

    logic                      load, start_fire;
    logic [pw:0]               sum;
    logic                      sum_wraps;
    logic [pw-1:0]             phase_next, start_phase;

    // Integer part at or beyond the table depth clamps just below one full turn.
    function automatic logic [pw-1:0] sat(input logic [pw-1:0] v);
        if ({1'b0, v[pw-1:frac_p]} >= (aw+1)'(depth_p))
            return phase_max;
        return v;
    endfunction

`ifdef SINE_SEQ_PHASE_OFFSET_EN
    assign start_phase = sat(offset_i);
`else
    assign start_phase = '0;
`endif

    // Step and phase are both below phase_span, so one subtraction always suffices.
    assign sum        = {1'b0, phase_q} + {1'b0, step_q};
    assign sum_wraps  = sum >= phase_span;
    assign phase_next = sum_wraps ? pw'(sum - phase_span) : sum[pw-1:0];

    always_comb begin
        state_d    = state_q;
        load       = 1'b0;
        start_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    start_fire = 1'b1;
                    state_d    = RUN;
                end
            end
            RUN: begin
                load = !valid_q || ready_i;
                if (stop_i)
                    state_d = STOPPING;
            end
            STOPPING: begin
                if (!valid_q || ready_i)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            phase_q <= '0;
            step_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wrap_q  <= load && sum_wraps;
            if (start_fire) begin
                phase_q <= start_phase;
                step_q  <= sat(step_i);
            end
            if (load) begin
                data_q  <= rd_data_i;
                valid_q <= 1'b1;
                phase_q <= phase_next;
            end else if (ready_i) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign rd_addr_o = phase_q[pw-1:frac_p];
    assign data_o    = data_q;
    assign valid_o   = valid_q;
    assign wrap_o    = wrap_q;
    assign busy_o    = (state_q != IDLE) || valid_q;

endmodule

// File: tb/tb_sine_phase_sequencer.sv
// Randomized scoreboard bench for sine_phase_sequencer against an arithmetic
// phase model; honours SINE_SEQ_PHASE_OFFSET_EN when defined.
module tb_sine_phase_sequencer;

    localparam int depth = 100;
    localparam int frac  = 8;
    localparam int aw    = 7;
    localparam int pw    = 15;
    localparam int span  = depth << frac;

    typedef struct packed {
        logic signed [11:0] data;
        logic               wrap;
    } exp_t;

    logic              clk = 1'b0;
    logic              reset_i = 1'b1;
    logic              start_i = 1'b0;
    logic              stop_i = 1'b0;
    logic              ready_i = 1'b0;
    logic [pw-1:0]     step_i = '0;
`ifdef SINE_SEQ_PHASE_OFFSET_EN
    logic [pw-1:0]     offset_i = '0;
`endif
    logic [aw-1:0]     rd_addr_o;
    logic signed [11:0] rd_data_i;
    logic signed [11:0] data_o;
    logic              valid_o, wrap_o, busy_o;

    exp_t q[$];
    int   errors = 0;
    int   checks = 0;
    int   n_acc = 0;

    always #5 clk = ~clk;

    // Distinct table values so a wrong address always shows as a wrong sample.
    function automatic logic signed [11:0] lut_val(input int a);
        return 12'(a * 37 - 1800);
    endfunction

    assign rd_data_i = lut_val(int'(rd_addr_o));

    sine_phase_sequencer dut (
        .clk_i     (clk),
        .reset_i   (reset_i),
        .start_i   (start_i),
        .stop_i    (stop_i),
        .step_i    (step_i),
`ifdef SINE_SEQ_PHASE_OFFSET_EN
        .offset_i  (offset_i),
`endif
        .rd_addr_o (rd_addr_o),
        .rd_data_i (rd_data_i),
        .data_o    (data_o),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .wrap_o    (wrap_o),
        .busy_o    (busy_o)
    );

    task automatic chk(input bit ok, input string name, input int act, input int exp);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int clamp(input int v);
        return (v / 256 >= depth) ? span - 1 : v;
    endfunction

    // Ideal sample stream of a run: phase advances by the clamped step modulo one turn.
    task automatic push_run(input int s, input int off, input int n);
        int   st, p;
        exp_t e;
        st = clamp(s);
        p  = clamp(off);
        for (int k = 0; k < n; k++) begin
            e.data = lut_val(p / 256);
            e.wrap = (p + st) >= span;
            q.push_back(e);
            p = (p + st) % span;
        end
    endtask

    // Monitor: pops on every newly presented sample, checks holds and wrap pulses.
    initial begin
        bit                 pv, pa;
        logic signed [11:0] pd;
        logic [aw-1:0]      pad;
        exp_t               e;
        pv = 0; pa = 0; pd = '0; pad = '0;
        forever begin
            @(negedge clk);
            if (reset_i) begin
                pv = 0;
                pa = 0;
            end else begin
                if (valid_o && (!pv || pa)) begin
                    if (q.size() == 0) begin
                        chk(0, "unexpected_sample", int'(data_o), 0);
                    end else begin
                        e = q.pop_front();
                        chk(data_o == e.data, "sample", int'(data_o), int'(e.data));
                        chk(wrap_o == e.wrap, "wrap_pulse", int'(wrap_o), int'(e.wrap));
                    end
                end else begin
                    chk(wrap_o == 1'b0, "wrap_quiet", int'(wrap_o), 0);
                end
                if (pv && !pa) begin
                    chk(valid_o == 1'b1, "stall_valid", int'(valid_o), 1);
                    chk(data_o == pd, "stall_data", int'(data_o), int'(pd));
                    chk(rd_addr_o == pad, "stall_addr", int'(rd_addr_o), int'(pad));
                end
                chk(int'(rd_addr_o) < depth, "addr_range", int'(rd_addr_o), depth - 1);
                if (valid_o && ready_i) n_acc++;
                pv  = valid_o;
                pa  = valid_o && ready_i;
                pd  = data_o;
                pad = rd_addr_o;
            end
        end
    end

    task automatic check_reset(input string tag);
        chk(valid_o == 1'b0, {tag, "_valid"}, int'(valid_o), 0);
        chk(data_o == 12'sd0, {tag, "_data"}, int'(data_o), 0);
        chk(wrap_o == 1'b0, {tag, "_wrap"}, int'(wrap_o), 0);
        chk(busy_o == 1'b0, {tag, "_busy"}, int'(busy_o), 0);
        chk(rd_addr_o == '0, {tag, "_addr"}, int'(rd_addr_o), 0);
    endtask

    // mode 0: ready high; 1: random ready; 2: ready high with a 3-cycle drop.
    task automatic run_seq(input int s, input int off, input int n, input int mode,
                           input bit stop_hold, input bit poke_start);
        int base, moff;
`ifdef SINE_SEQ_PHASE_OFFSET_EN
        moff = off;
`else
        moff = 0;
`endif
        @(posedge clk); #1;
        start_i = 1'b1;
        step_i  = pw'(s);
`ifdef SINE_SEQ_PHASE_OFFSET_EN
        offset_i = pw'(off);
`endif
        ready_i = 1'b1;
        push_run(s, moff, n + 6);
        base = n_acc;
        @(posedge clk); #1;
        start_i = 1'b0;
        step_i  = pw'($urandom_range(0, 32767));
        chk(valid_o == 1'b0, "start_lat1", int'(valid_o), 0);
        chk(busy_o == 1'b1, "busy_run", int'(busy_o), 1);
        @(posedge clk); #1;
        chk(valid_o == 1'b1, "start_lat2", int'(valid_o), 1);
        for (int i = 0; i < n; i++) begin
            case (mode)
                0: ready_i = 1'b1;
                1: ready_i = ($urandom_range(0, 3) != 0);
                default: ready_i = !(i >= n / 2 && i < n / 2 + 3);
            endcase
            start_i = poke_start && (i == n / 3);
            if (start_i) step_i = pw'($urandom_range(0, 32767));
            @(posedge clk); #1;
        end
        start_i = 1'b0;
        stop_i  = 1'b1;
        ready_i = !stop_hold;
        @(posedge clk); #1;
        stop_i = 1'b0;
        if (stop_hold) begin
            for (int k = 0; k < 3; k++) begin
                chk(busy_o == 1'b1, "stopping_busy", int'(busy_o), 1);
                chk(valid_o == 1'b1, "stopping_valid", int'(valid_o), 1);
                @(posedge clk); #1;
            end
            ready_i = 1'b1;
            @(posedge clk); #1;
            chk(busy_o == 1'b0, "stop_done_busy", int'(busy_o), 0);
            chk(valid_o == 1'b0, "stop_done_valid", int'(valid_o), 0);
        end else begin
            for (int k = 0; k < 20 && busy_o; k++) begin
                @(posedge clk); #1;
            end
            chk(busy_o == 1'b0, "idle_timeout", int'(busy_o), 0);
            if (mode == 0)
                chk(n_acc - base == n + 2, "sample_count", n_acc - base, n + 2);
        end
        chk(n_acc - base > 0, "samples_seen", n_acc - base, 1);
        q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        reset_i = 1'b0;
        @(posedge clk); #1;
        check_reset("por");

        stop_i = 1'b1;
        @(posedge clk); #1;
        stop_i = 1'b0;
        chk(busy_o == 1'b0, "stop_in_idle", int'(busy_o), 0);

        run_seq(256, 0, 100, 0, 0, 0);
        run_seq(640, 0, 60, 0, 0, 0);
        run_seq(256 * 7 + 3, 0, 40, 2, 0, 1);
        run_seq(120 << 8, 0, 30, 0, 1, 0);
        run_seq(32767, 0, 20, 1, 0, 0);
        run_seq(0, 0, 8, 0, 0, 0);
        run_seq(256, 25 << 8, 10, 0, 0, 0);
        run_seq(300, 120 << 8, 12, 1, 1, 0);

        for (int r = 0; r < 6; r++)
            run_seq($urandom_range(0, 32767), $urandom_range(0, 32767),
                    $urandom_range(5, 60), $urandom_range(0, 2),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        @(posedge clk); #1;
        start_i = 1'b1;
        step_i  = pw'(1234);
        ready_i = 1'b1;
        push_run(1234, 0, 40);
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int i = 0; i < 15; i++) begin
            ready_i = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        reset_i = 1'b1;
        @(posedge clk); #1;
        check_reset("midrun_reset");
        reset_i = 1'b0;
        q.delete();
        @(posedge clk); #1;
        check_reset("after_reset");

        run_seq(512, 0, 25, 1, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
